// File: rtl/prefetch_stream_fifo_pkg.sv
// Shared entry encoding for the prefetch byte-stream queue.
// DATA entries carry a 1..8 byte code chunk; LIMIT and FAULT markers carry no bytes.
package prefetch_stream_fifo_pkg;

  localparam int PFQ_ENTRY_W = 70;

  typedef enum logic [1:0] {
    PFQ_TYPE_DATA  = 2'd0,
    PFQ_TYPE_LIMIT = 2'd1,
    PFQ_TYPE_FAULT = 2'd2
  } pfq_type_e;

  typedef struct packed {
    pfq_type_e   kind;
    logic [3:0]  len;
    logic [63:0] data;
  } pfq_entry_t;

  // Out-of-range chunk lengths are stored as a full 8-byte chunk
  function automatic logic [3:0] pfq_clamp_len(input logic [3:0] len);
    return ((len == 4'd0) || (len > 4'd8)) ? 4'd8 : len;
  endfunction

endpackage

// File: rtl/prefetch_stream_ram.sv
// Entry storage for the prefetch queue: two write slots per cycle, asynchronous head read.
module prefetch_stream_ram
  import prefetch_stream_fifo_pkg::*;
#(
  parameter  int DEPTH = 16,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we0,
  input  logic [AW-1:0] wr_addr0,
  input  pfq_entry_t    wr_data0,
  input  logic          we1,
  input  logic [AW-1:0] wr_addr1,
  input  pfq_entry_t    wr_data1,
  input  logic [AW-1:0] rd_addr,
  output pfq_entry_t    rd_data
);

  pfq_entry_t mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we0) mem[wr_addr0] <= wr_data0;
    if (we1) mem[wr_addr1] <= wr_data1;
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/prefetch_stream_fifo.sv
// Byte-stream queue between the prefetch/icache path and the decoder.
// The decoder sees a little-endian window of the head chunk and consumes 0..8 bytes per cycle.
module prefetch_stream_fifo
  import prefetch_stream_fifo_pkg::*;
#(
  parameter  int DEPTH = 16,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        pr_reset,
  input  logic        wr_do,
  input  logic [63:0] wr_data,
  input  logic [3:0]  wr_length,
  input  logic        limit_do,
  input  logic        fault_do,
  output logic        wr_full,
  output logic [AW:0] used,
  output logic [3:0]  fetch_valid,
  output logic [63:0] fetch,
  output logic        fetch_limit,
  output logic        fetch_page_fault,
  input  logic        accept_do,
  input  logic [3:0]  accept_length
);

  localparam logic [AW:0] DEPTH_V = (AW+1)'(DEPTH);
  localparam logic [AW:0] ONE_V   = (AW+1)'(1);

  logic [AW:0] rd_ptr, wr_ptr, rd_ptr_nxt, wr_ptr_nxt, used_after_data, used_nxt;
  logic [3:0]  off, off_nxt, take;
  logic        empty, accept_ok, pop, data_ok, mark_req, mark_ok, we0, we1;
  pfq_entry_t  head, data_entry, mark_entry, wr_data0;

  assign used  = wr_ptr - rd_ptr;
  assign empty = (used == '0);

  prefetch_stream_ram #(.DEPTH(DEPTH)) u_ram (
    .clk      (clk),
    .we0      (we0),
    .wr_addr0 (wr_ptr[AW-1:0]),
    .wr_data0 (wr_data0),
    .we1      (we1),
    .wr_addr1 (wr_ptr[AW-1:0] + 1'b1),
    .wr_data1 (mark_entry),
    .rd_addr  (rd_ptr[AW-1:0]),
    .rd_data  (head)
  );

  always_comb begin
    fetch_valid      = 4'd0;
    fetch            = head.data >> {off, 3'b000};
    fetch_limit      = 1'b0;
    fetch_page_fault = 1'b0;
    if (!empty) begin
      case (head.kind)
        PFQ_TYPE_DATA:  fetch_valid      = head.len - off;
        PFQ_TYPE_LIMIT: fetch_limit      = 1'b1;
        PFQ_TYPE_FAULT: fetch_page_fault = 1'b1;
        default:        fetch_valid      = 4'd0;
      endcase
    end
  end

  // Consume side: markers report fetch_valid=0, so they can never be popped
  always_comb begin
    accept_ok = accept_do && (fetch_valid != 4'd0);
    take      = (accept_length < fetch_valid) ? accept_length : fetch_valid;
    pop       = accept_ok && ((off + take) == head.len);
    off_nxt   = off;
    if (pop)            off_nxt = 4'd0;
    else if (accept_ok) off_nxt = off + take;
  end

  // Push side: DATA takes the first free slot, a marker (FAULT wins over LIMIT) the next one
  always_comb begin
    data_entry.kind = PFQ_TYPE_DATA;
    data_entry.len  = pfq_clamp_len(wr_length);
    data_entry.data = wr_data;
    mark_entry.kind = fault_do ? PFQ_TYPE_FAULT : PFQ_TYPE_LIMIT;
    mark_entry.len  = 4'd0;
    mark_entry.data = 64'd0;

    data_ok         = wr_do && (used != DEPTH_V);
    used_after_data = used + {{AW{1'b0}}, data_ok};
    mark_req        = limit_do || fault_do;
    mark_ok         = mark_req && (used_after_data != DEPTH_V);

    we0      = !pr_reset && (data_ok || mark_ok);
    we1      = !pr_reset && data_ok && mark_ok;
    wr_data0 = data_ok ? data_entry : mark_entry;

    wr_ptr_nxt = wr_ptr + {{AW{1'b0}}, data_ok} + {{AW{1'b0}}, mark_ok};
    rd_ptr_nxt = rd_ptr + {{AW{1'b0}}, pop};
    used_nxt   = wr_ptr_nxt - rd_ptr_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      off     <= 4'd0;
      wr_full <= 1'b0;
    end else if (pr_reset) begin
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      off     <= 4'd0;
      wr_full <= 1'b0;
    end else begin
      rd_ptr  <= rd_ptr_nxt;
      wr_ptr  <= wr_ptr_nxt;
      off     <= off_nxt;
      wr_full <= (used_nxt >= (DEPTH_V - ONE_V));
    end
  end

  // Protocol checks on upstream and decoder behaviour
  always_ff @(posedge clk) begin
    if (rst_n && !pr_reset) begin
      assert (!wr_do || ((wr_length != 4'd0) && (wr_length <= 4'd8)));
      assert ((!wr_do || data_ok) && (!mark_req || mark_ok));
      assert (!accept_ok || (accept_length <= fetch_valid));
    end
  end

endmodule
